tmvp_stream_loader: RTL and testbench
=====================================

Name: tmvp_stream_loader

Overview:
AXI4-Stream slave that fills one operand BRAM (f or g) for the TMVP core before a run. It accepts REAL_N coefficients and writes them to consecutive BRAM addresses through a write-only port. It then zero-pads addresses REAL_N..N-1 and pulses done. One instance sits in front of each dual_port_ram_TMVP port used by Top_TMVP; this block is the producer side of the BRAM read interface that Top_TMVP consumes.

Parameters:
N, 512, padded polynomial length; BRAM depth; address width is $clog2(N)
REAL_N, 509, number of real coefficients; 1 <= REAL_N <= N
DATA_WIDTH, 8, coefficient / stream word width

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a load when idle
s_axis_tdata  input  DATA_WIDTH  coefficient word
s_axis_tvalid  input  1  word valid
s_axis_tready  output  1  block accepts a word this cycle
s_axis_tlast  input  1  marks last coefficient of the vector
bram_address  output  $clog2(N)  BRAM write address
bram_data_in  output  DATA_WIDTH  BRAM write data
bram_we  output  1  BRAM write enable
busy  output  1  high from start acceptance until done
done  output  1  one-cycle pulse when BRAM is fully written
len_error  output  1  sticky; tlast position differs from REAL_N-1

Behaviour:
- Reset values: s_axis_tready=0, bram_we=0, bram_address=0, bram_data_in=0, busy=0, done=0, len_error=0, state=IDLE, count=0.
- FSM states: IDLE, LOAD, PAD, FIN.
- IDLE: start=1 -> LOAD, count<=0, len_error<=0, busy<=1. start in any other state is ignored.
- LOAD: s_axis_tready=1 (combinational from state == LOAD). A beat is accepted on the edge where tvalid && tready.
  - Write timing: one cycle after acceptance, bram_we=1, bram_address=count, bram_data_in=tdata (registered). count then increments.
  - No accepted beat in a cycle -> bram_we=0 in the following cycle. Bubbles in tvalid are allowed.
- LOAD exit, checked on each accepted beat:
  - count==REAL_N-1 and tlast=1 -> PAD, no error.
  - count==REAL_N-1 and tlast=0 -> PAD, len_error<=1. Further beats are not accepted because tready is now 0.
  - count<REAL_N-1 and tlast=1 -> PAD, len_error<=1. The remaining addresses count+1..N-1 are zero-filled.
- PAD: one write per cycle, registered. bram_we=1, bram_data_in=0, address=count, through address N-1. Last pad write -> FIN. If count==N already, PAD issues no writes and goes straight to FIN.
- FIN: done=1 for exactly one cycle, the cycle after the final write cycle. busy<=0. Next state IDLE.
- Latency (defaults): last beat accepted at edge E0 -> word 508 written in the cycle after E0 -> pad writes 509, 510, 511 in the next three cycles -> done in the fifth cycle after E0.
- Address never exceeds N-1. There is no wrap-around; count is $clog2(N)+1 bits wide.
- Reset mid-operation: on the next edge all outputs return to reset values. No further writes are issued. Partial BRAM contents are left as is.
- start coincident with reset: reset wins.

Optional Feature:
TMVP_LOADER_ZEROPAD_EN
- Defined: PAD state present, behaviour as above.
- Undefined: PAD is removed. LOAD exits directly to FIN, and addresses above the last written word are untouched. done comes 2 cycles after the last accepted beat. Early tlast still sets len_error.

Test Plan:
- Reset, start, stream 509 words 0..508 (mod 256) continuously, tlast on word 508 -> BRAM[i]=i mod 256 for i<509, BRAM[509..511]=0, len_error=0, done pulses once, 5 cycles after the last accept edge.
- Same stream with tvalid deasserted every other cycle -> identical BRAM contents. bram_we is never high for an unaccepted beat.
- tlast on word 99 (100 words) -> BRAM[100..511]=0, len_error=1, done pulses, tready=0 after word 99.
- 509 words without tlast, then 3 extra valid words -> extras not accepted (tready=0), len_error=1, BRAM[509..511]=0.
- Assert reset after 200 accepted words -> next cycle bram_we=0, busy=0, tready=0. A new start followed by a full vector loads correctly.
- start pulsed while busy (mid-LOAD) -> ignored, count continues, single done pulse. With TMVP_LOADER_ZEROPAD_EN undefined, a full load -> done 2 cycles after the last accept and BRAM[509..511] unchanged.

Source files
------------

// File: rtl/tmvp_stream_loader.sv
// AXI4-Stream loader that fills one TMVP operand BRAM, then zero-pads it.
// Define TMVP_LOADER_ZEROPAD_EN to zero-fill addresses past the last word.
module tmvp_stream_loader #(
  parameter int N          = 512,
  parameter int REAL_N     = 509,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [$clog2(N)-1:0]  bram_address,
  output logic [DATA_WIDTH-1:0] bram_data_in,
  output logic                  bram_we,
  output logic                  busy,
  output logic                  done,
  output logic                  len_error
);

  localparam int AW = $clog2(N);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PAD,
    FIN
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] count;
  logic          accept;
  logic          last_cnt;

  assign s_axis_tready = (state == LOAD);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign last_cnt      = (count == CW'(REAL_N - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        if (accept && (last_cnt || s_axis_tlast)) begin
`ifdef TMVP_LOADER_ZEROPAD_EN
          state_nx = PAD;
`else
          state_nx = FIN;
`endif
        end
      end
`ifdef TMVP_LOADER_ZEROPAD_EN
      PAD: begin
        // count == N means nothing is left to pad
        if (count >= CW'(N - 1)) state_nx = FIN;
      end
`endif
      FIN: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= '0;
      bram_we      <= 1'b0;
      bram_address <= '0;
      bram_data_in <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      len_error    <= 1'b0;
    end else begin
      bram_we <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            count     <= '0;
            len_error <= 1'b0;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            bram_we      <= 1'b1;
            bram_address <= count[AW-1:0];
            bram_data_in <= s_axis_tdata;
            count        <= count + 1'b1;
            if (last_cnt != s_axis_tlast) len_error <= 1'b1;
          end
        end
`ifdef TMVP_LOADER_ZEROPAD_EN
        PAD: begin
          if (count < CW'(N)) begin
            bram_we      <= 1'b1;
            bram_address <= count[AW-1:0];
            bram_data_in <= '0;
            count        <= count + 1'b1;
          end
        end
`endif
        FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmvp_stream_loader.sv
// Scoreboard bench for tmvp_stream_loader; BRAM writes are checked in order.
// Honours TMVP_LOADER_ZEROPAD_EN for pad writes and done latency.
module tb_tmvp_stream_loader;

  localparam int N      = 512;
  localparam int REAL_N = 509;
  localparam int DW     = 8;
  localparam int AW     = $clog2(N);
`ifdef TMVP_LOADER_ZEROPAD_EN
  localparam int LAT    = 5;
  localparam bit PADDED = 1'b1;
`else
  localparam int LAT    = 2;
  localparam bit PADDED = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          start;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [AW-1:0] bram_address;
  logic [DW-1:0] bram_data_in;
  logic          bram_we;
  logic          busy;
  logic          done;
  logic          len_error;

  tmvp_stream_loader #(
    .N          (N),
    .REAL_N     (REAL_N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .bram_address  (bram_address),
    .bram_data_in  (bram_data_in),
    .bram_we       (bram_we),
    .busy          (busy),
    .done          (done),
    .len_error     (len_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int d;
  } wr_t;

  wr_t           q[$];
  wr_t           e;
  logic [DW-1:0] mem[N];
  logic [DW-1:0] exp_mem[N];
  int            n_tests  = 0;
  int            n_fail   = 0;
  int            tb_cnt   = 0;
  int            cyc      = 0;
  int            last_acc = 0;
  int            done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (bram_we === 1'b1) begin
      if (q.size() == 0) begin
        chk("spur_we", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("wr_addr", 32'(bram_address), 32'(e.a));
        chk("wr_data", 32'(bram_data_in), 32'(e.d));
      end
      mem[bram_address] = bram_data_in;
    end
    if (done === 1'b1) begin
      done_cnt++;
      chk("done_lat", 32'(cyc - last_acc), 32'(LAT));
    end
    if (reset) begin
      q.delete();
      tb_cnt = 0;
    end else begin
      if (start && !busy) tb_cnt = 0;
      if (s_axis_tvalid && s_axis_tready) begin
        q.push_back('{tb_cnt, int'(s_axis_tdata)});
        last_acc = cyc;
        if (PADDED && (s_axis_tlast || tb_cnt == REAL_N - 1))
          for (int a = tb_cnt + 1; a < N; a++) q.push_back('{a, 0});
        tb_cnt++;
      end
    end
  end

  task automatic run_load(input int n, input int last_idx, input bit gaps,
                          input int extras, input int pat,
                          input bit mid_start, input int abort_at);
    int sent = 0;
    int g    = 0;
    int d0   = done_cnt;
    bit acc;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (sent < n && g < 4000) begin
      g++;
      s_axis_tvalid = gaps ? g[0] : 1'b1;
      s_axis_tdata  = DW'(pat + sent);
      s_axis_tlast  = (sent == last_idx);
      start         = mid_start && (sent == 50);
      reset         = (sent == abort_at);
      acc = s_axis_tvalid && s_axis_tready && !reset;
      @(posedge clk); #1;
      if (acc) sent++;
      if (reset || !s_axis_tready) break;
    end
    start        = 1'b0;
    s_axis_tlast = 1'b0;
    if (reset) begin
      chk("rst_we", 32'(bram_we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rdy", 32'(s_axis_tready), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      reset         = 1'b0;
      s_axis_tvalid = 1'b0;
      return;
    end
    for (int i = 0; i < extras; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'hEE;
      @(posedge clk); #1;
      chk("extra_rdy", 32'(s_axis_tready), 32'd0);
    end
    s_axis_tvalid = 1'b0;
    g = 0;
    while (done_cnt == d0 && g < 1000) begin
      @(posedge clk); #1;
      g++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("len_err", 32'(len_error), 32'(last_idx != REAL_N - 1));
    chk("q_empty", 32'(q.size()), 32'd0);
    for (int i = 0; i < sent; i++) exp_mem[i] = DW'(pat + i);
    if (PADDED)
      for (int i = sent; i < N; i++) exp_mem[i] = '0;
    for (int i = 0; i < N; i++)
      chk($sformatf("mem[%0d]", i), 32'(mem[i]), 32'(exp_mem[i]));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      mem[i]     = '0;
      exp_mem[i] = '0;
    end
    reset         = 1'b1;
    start         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy0", 32'(s_axis_tready), 32'd0);
    chk("rst_we0", 32'(bram_we), 32'd0);
    chk("rst_addr0", 32'(bram_address), 32'd0);
    chk("rst_data0", 32'(bram_data_in), 32'd0);
    chk("rst_busy0", 32'(busy), 32'd0);
    chk("rst_done0", 32'(done), 32'd0);
    chk("rst_lerr0", 32'(len_error), 32'd0);
    reset = 1'b0;

    run_load(509, 508, 1'b0, 0, 0, 1'b0, -1);
    run_load(509, 508, 1'b1, 0, 0, 1'b0, -1);
    run_load(100, 99, 1'b0, 0, 5, 1'b0, -1);
    run_load(509, -1, 1'b0, 3, 9, 1'b0, -1);
    run_load(509, 508, 1'b0, 0, 17, 1'b0, 200);
    run_load(509, 508, 1'b0, 0, 33, 1'b0, -1);
    run_load(509, 508, 1'b1, 0, 51, 1'b1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
